// File: rtl/motion_phase_sequencer_pkg.sv
// motion_pkg: shared types for the motion phase sequencer and the step
// generators that consume its phase/tick outputs.
//   timing_t    : cumulative tick boundary / elapsed tick count
//   param_t     : one motion parameter (per phase or end-of-move)
//   phase_t     : phase index 0..3
//   seq_state_t : sequencer FSM state, also exported for debug
package motion_pkg;

  localparam int NUM_PHASES = 4;

  typedef logic [63:0] timing_t;
  typedef logic [31:0] param_t;
  typedef logic [1:0]  phase_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/motion_phase_sequencer_tick_prescaler.sv
// tick_prescaler: free-running divider that produces one wrap strobe every
// DIV enabled clock cycles. Holding en low freezes the count, so a paused
// motion resumes mid-period. clr restarts the period from zero.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   en         : count this cycle
//   clr        : force count to zero (wins over en)
//   wrap       : combinational strobe, high on the enabled cycle whose
//                count is DIV-1
module tick_prescaler #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] count;

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 16'd1;
    end
  end

endmodule

// File: rtl/motion_phase_sequencer.sv
// motion_phase_sequencer: runs one move from the winning axis's timing.
// On start it latches four cumulative phase boundaries and five params,
// checks the boundaries are monotonic, then walks motion ticks (one per
// TICK_DIV clocks), publishing the current phase and its param.
// Optional build macro: MOTION_PHASE_SEQ_PAUSE_EN adds a pause input that
// freezes the prescaler and elapsed count while RUN.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   start          : one-cycle request, accepted only in IDLE
//   stop           : abort any non-IDLE move
//   pause          : (macro only) hold the move in RUN
//   timing[0:3]    : cumulative tick boundaries, timing[3] = move length
//   params[0:4]    : per-phase params 0..3, end-of-move param 4
//   busy           : move in progress
//   tick           : one-cycle strobe per motion tick
//   phase          : current phase index
//   cur_param      : param of the current phase
//   end_param      : latched params[4]
//   elapsed        : ticks completed in this move
//   finish/aborted/error : one-cycle completion pulses
//   debug_state    : FSM state
// Handshake: start is a request with no ready; it is taken when the block is
// in IDLE (busy=0) and silently dropped otherwise. All outputs are registered.
module motion_phase_sequencer
  import motion_pkg::*;
#(
  parameter int TICK_DIV = 50,
  parameter int TW       = 64,
  parameter int PW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
`ifdef MOTION_PHASE_SEQ_PAUSE_EN
  input  logic          pause,
`endif
  input  logic [TW-1:0] timing [0:3],
  input  logic [PW-1:0] params [0:4],
  output logic          busy,
  output logic          tick,
  output phase_t        phase,
  output logic [PW-1:0] cur_param,
  output logic [PW-1:0] end_param,
  output logic [TW-1:0] elapsed,
  output logic          finish,
  output logic          aborted,
  output logic          error,
  output seq_state_t    debug_state
);

  seq_state_t    state, state_nxt;
  logic [TW-1:0] t_q [0:NUM_PHASES-1];
  logic [PW-1:0] p_q [0:NUM_PHASES-1];
  logic [TW-1:0] elapsed_nxt;
  phase_t        elapsed_phase;
  logic          monotonic;
  logic          paused;
  logic          accept;
  logic          run_en;
  logic          wrap;
  logic          finish_nxt, aborted_nxt, error_nxt;

`ifdef MOTION_PHASE_SEQ_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign accept      = (state == IDLE) && start;
  assign run_en      = (state == RUN) && !stop && !paused;
  assign elapsed_nxt = elapsed + TW'(1);
  assign monotonic   = (t_q[0] <= t_q[1]) && (t_q[1] <= t_q[2]) && (t_q[2] <= t_q[3]);
  assign debug_state = state;

  // Smallest phase whose end boundary lies beyond the ticks already done.
  // Zero-length phases fail the compare and are skipped naturally.
  always_comb begin
    elapsed_phase = phase_t'(NUM_PHASES - 1);
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (elapsed < t_q[i]) elapsed_phase = phase_t'(i);
    end
  end

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (run_en),
    .clr   (accept),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    finish_nxt  = 1'b0;
    aborted_nxt = 1'b0;
    error_nxt   = 1'b0;
    if (state != IDLE && stop) begin
      state_nxt   = IDLE;
      aborted_nxt = 1'b1;
    end else begin
      case (state)
        IDLE:  if (start) state_nxt = CHECK;
        CHECK: begin
          if (!monotonic) begin
            state_nxt = IDLE;
            error_nxt = 1'b1;
          end else if (t_q[3] == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
          end
        end
        RUN:   if (wrap && (elapsed_nxt == t_q[3])) state_nxt = DONE;
        DONE: begin
          state_nxt  = IDLE;
          finish_nxt = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= 1'b0;
      tick      <= 1'b0;
      phase     <= '0;
      cur_param <= '0;
      end_param <= '0;
      elapsed   <= '0;
      finish    <= 1'b0;
      aborted   <= 1'b0;
      error     <= 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
        t_q[i] <= '0;
        p_q[i] <= '0;
      end
    end else begin
      busy    <= (state_nxt != IDLE);
      tick    <= wrap;
      finish  <= finish_nxt;
      aborted <= aborted_nxt;
      error   <= error_nxt;
      if (accept) begin
        for (int i = 0; i < NUM_PHASES; i++) begin
          t_q[i] <= timing[i];
          p_q[i] <= params[i];
        end
        end_param <= params[4];
        elapsed   <= '0;
      end
      if (wrap) elapsed <= elapsed_nxt;
      // Phase trails elapsed by one cycle; it is also refreshed on the
      // final tick so the last tick reports the phase it belongs to.
      if ((state == CHECK && state_nxt == RUN) ||
          (state == RUN && state_nxt != IDLE)) begin
        phase     <= elapsed_phase;
        cur_param <= p_q[elapsed_phase];
      end
    end
  end

endmodule
